// File: rtl/chunked_wide_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : chunked_wide_adder_if
//  Description : Operand/result handshake bundle for chunked_wide_adder.
//                The ovf signal exists only when SIGNED_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface chunked_wide_adder_if #(
    parameter int W = 40
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SIGNED_OVF_EN
    logic         ovf;
`endif

    // Producer of operands / consumer of results
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SIGNED_OVF_EN
        , input ovf
`endif
    );

    // The sequencer itself
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SIGNED_OVF_EN
        , output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/chunked_wide_adder.sv
`default_nettype none
// ============================================================================
//  Module      : chunked_wide_adder (with ripple_carry_10bit)
//  Description : Multi-cycle wide adder. Feeds one 10-bit ripple-carry adder
//                a chunk per cycle, LSB chunk first, carrying between cycles
//                and assembling the full sum in a shift register.
//                Optional macro SIGNED_OVF_EN adds a signed overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================

// 10-bit ripple-carry adder: the only arithmetic on the datapath.
module ripple_carry_10bit (
    input  logic [9:0] i_a,
    input  logic [9:0] i_b,
    input  logic       i_cin,
    output logic [9:0] o_s,
    output logic       o_cout
);
    logic [10:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < 10; i++) begin : g_bit
        assign o_s[i]         = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[10];
endmodule

module chunked_wide_adder #(
    parameter int NUM_CHUNKS = 4,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chunked_wide_adder_if.slave  bus
);
    localparam int              c_W        = 10 * NUM_CHUNKS;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [c_W-1:0]   r_a;
    logic [c_W-1:0]   r_b;
    logic [c_W-1:0]   r_sum;
    logic             r_cout;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_cnt_end;

    logic [9:0]       w_chunk_s;
    logic             w_chunk_cout;
    logic [c_W-1:0]   w_sum_nxt;

    // Single shared chunk adder, always looking at the low chunk of the operands
    ripple_carry_10bit u_rca (
        .i_a    (r_a[9:0]),
        .i_b    (r_b[9:0]),
        .i_cin  (r_carry),
        .o_s    (w_chunk_s),
        .o_cout (w_chunk_cout)
    );

    // New chunk result enters at the top; earlier chunks drift toward bit 0
    if (NUM_CHUNKS == 1) begin : g_single_chunk
        assign w_sum_nxt = w_chunk_s;
    end else begin : g_multi_chunk
        assign w_sum_nxt = {w_chunk_s, r_sum[c_W-1:10]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        w_cnt_end   = (r_cnt >= c_LAST_CNT);
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_step = 1'b1;
                if (r_cnt == c_LAST_CNT) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt > c_LAST_CNT) begin
                    // Counter code outside the chunk range: abandon the op
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand shift registers, chunk carry, counter and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> 10;
            r_b     <= r_b >> 10;
            r_sum   <= w_sum_nxt;
            r_carry <= w_chunk_cout;
            // Counter never runs past the last chunk index
            r_cnt   <= w_cnt_end ? '0 : r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout <= w_chunk_cout;
            end
        end
    end

`ifdef SIGNED_OVF_EN
    logic r_sa;
    logic r_sb;
    logic r_ovf;

    // Operand signs captured at acceptance; overflow judged on the final chunk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_sa  <= bus.a[c_W-1];
            r_sb  <= bus.b[c_W-1];
        end else if (w_last) begin
            r_ovf <= (r_sa == r_sb) && (w_chunk_s[9] != r_sa);
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_chunked_wide_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chunked_wide_adder
//  Description : Self-checking bench for chunked_wide_adder (NUM_CHUNKS=4).
//                Checks ovf too when SIGNED_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chunked_wide_adder;
    localparam int NUM_CHUNKS = 4;
    localparam int CNT_W      = 4;
    localparam int W          = 10 * NUM_CHUNKS;
    localparam int TIMEOUT    = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    chunked_wide_adder_if #(.W(W)) bus ();

    chunked_wide_adder #(
        .NUM_CHUNKS (NUM_CHUNKS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, TIMEOUT);
    endtask

    // Independent reference: plain wide addition
    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        vec_t       v;
        logic [W:0] t;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        v.a    = a;
        v.b    = b;
        v.cin  = cin;
        v.sum  = t[W-1:0];
        v.cout = t[W];
        v.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return v;
    endfunction

    function automatic vec_t fix(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input logic [W-1:0] s, input logic co, input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sum = s; v.cout = co; v.ovf = ov;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge
    task automatic start_op(input vec_t v);
        exp_t e;
        int   t = 0;
        while (!bus.in_ready && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        if (t >= TIMEOUT) fail_now("in_ready_wait");
        bus.in_valid = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.cin      = v.cin;
        e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
        sb.push_back(e);
        @(negedge clk);
        // Scramble operands: only the acceptance-edge values may matter
        bus.in_valid = 1'b0;
        bus.a        = ~v.a;
        bus.b        = ~v.b;
        bus.cin      = ~v.cin;
    endtask

    // Waits for out_valid, checks latency, busy handshake and result; stays in DONE
    task automatic finish_op(input string name);
        exp_t e;
        int   lat     = 0;
        logic busy_ok = 1'b1;
        while (!bus.out_valid && lat < TIMEOUT) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (lat >= TIMEOUT) begin
            fail_now({name, "_out_valid_wait"});
        end else begin
            check({name, "_latency"}, W'(lat), W'(NUM_CHUNKS));
            check({name, "_in_ready_busy"}, W'(busy_ok), W'(1));
            check({name, "_in_ready_done"}, W'(bus.in_ready), W'(0));
            if (sb.size() == 0) begin
                fail_now({name, "_scoreboard_empty"});
            end else begin
                e = sb.pop_front();
                check({name, "_sum"}, bus.sum, e.sum);
                check({name, "_cout"}, W'(bus.cout), W'(e.cout));
`ifdef SIGNED_OVF_EN
                check({name, "_ovf"}, W'(bus.ovf), W'(e.ovf));
`endif
            end
        end
    endtask

    task automatic release_op(input string name);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, "_out_valid_drop"}, W'(bus.out_valid), W'(0));
        check({name, "_in_ready_back"}, W'(bus.in_ready), W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;

        vecs.push_back(fix(40'h00_0000_03FF, 40'h1, 1'b0, 40'h00_0000_0400, 1'b0, 1'b0));
        vecs.push_back(fix(40'hFF_FFFF_FFFF, 40'h0, 1'b1, 40'h0, 1'b1, 1'b0));
        vecs.push_back(fix(40'h7F_FFFF_FFFF, 40'h1, 1'b0, 40'h80_0000_0000, 1'b0, 1'b1));
        vecs.push_back(fix(40'h80_0000_0000, 40'hFF_FFFF_FFFF, 1'b0, 40'h7F_FFFF_FFFF, 1'b1, 1'b1));
        vecs.push_back(fix(40'h5, 40'h7, 1'b0, 40'hC, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++) begin
            vecs.push_back(mk({8'($urandom()), $urandom()}, {8'($urandom()), $urandom()}, 1'($urandom())));
        end

        // Reset state, observed while reset is still asserted
        repeat (3) @(negedge clk);
        check("reset_in_ready", W'(bus.in_ready), W'(1));
        check("reset_out_valid", W'(bus.out_valid), W'(0));
        check("reset_sum", bus.sum, '0);
        check("reset_cout", W'(bus.cout), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i]);
            finish_op($sformatf("vec%0d", i));
            release_op($sformatf("vec%0d", i));
        end

        // Result held in DONE with out_ready low and new requests pending
        start_op(fix(40'h12_3456_789A, 40'h11_1111_1111, 1'b0, 40'h23_4567_89AB, 1'b0, 1'b0));
        finish_op("hold");
        held = bus.sum;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = {8'($urandom()), $urandom()};
            bus.b        = {8'($urandom()), $urandom()};
            @(negedge clk);
            check($sformatf("hold_sum_%0d", k), bus.sum, 40'h23_4567_89AB);
            check($sformatf("hold_in_ready_%0d", k), W'(bus.in_ready), W'(0));
            check($sformatf("hold_out_valid_%0d", k), W'(bus.out_valid), W'(1));
        end
        bus.in_valid = 1'b0;
        release_op("hold");
        check("hold_sum_after_release", bus.sum, held);
        repeat (3) @(negedge clk);
        check("hold_no_extra_result", W'(bus.out_valid), W'(0));

        // Leave cout=1 behind, then reset in the middle of the next op
        start_op(fix(40'h3, 40'hFF_FFFF_FFFF, 1'b0, 40'h2, 1'b1, 1'b0));
        finish_op("neg_one");
        release_op("neg_one");
        start_op(fix(40'h12_3456_789A, 40'h11_1111_1111, 1'b0, 40'h23_4567_89AB, 1'b0, 1'b0));
        repeat (2) @(negedge clk);      // counter now 2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        check("midreset_out_valid", W'(bus.out_valid), W'(0));
        check("midreset_in_ready", W'(bus.in_ready), W'(1));
        check("midreset_sum", bus.sum, '0);
        check("midreset_cout", W'(bus.cout), W'(0));
        repeat (NUM_CHUNKS + 1) @(negedge clk);
        check("midreset_no_partial", W'(bus.out_valid), W'(0));
        start_op(fix(40'h5, 40'h7, 1'b0, 40'hC, 1'b0, 1'b0));
        finish_op("after_reset");
        release_op("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
